// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
//
// Shared definitions for the audio synthesiser: waveform mode encodings,
// per-channel register offsets, CTRL register bit positions and the noise
// LFSR seed/taps together with its step function.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package audio_pkg;

    // Waveform selected by CTRL bits 2:1.
    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_NOISE  = 2'd3
    } wave_mode_e;

    // Register selected by waddr[1:0] inside a channel.
    typedef enum logic [1:0] {
        REG_PERIOD   = 2'd0,
        REG_VOLUME   = 2'd1,
        REG_CTRL     = 2'd2,
        REG_RESERVED = 2'd3
    } reg_sel_e;

    // CTRL register layout.
    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_MODE_LSB      = 1;
    localparam int CTRL_MODE_MSB      = 2;
    localparam int CTRL_PHASE_RST_BIT = 3;

    // Noise generator: 15-bit right-shifting LFSR, feedback into the MSB.
    localparam int                    LFSR_WIDTH = 15;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 15'h7FFF;
    localparam int                    LFSR_TAP_A = 0;
    localparam int                    LFSR_TAP_B = 1;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] state);
        return {state[LFSR_TAP_A] ^ state[LFSR_TAP_B], state[LFSR_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/audio_channel.sv
// ---------------------------------------------------------------------------
// audio_channel
//
// One synthesiser voice: PERIOD/VOLUME/CTRL registers, period counter,
// waveform state (square level, saw/triangle phase, noise LFSR), waveform
// selection, volume scaling and the stage-1 sample register.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   period_we_i  in   write strobe for this channel's PERIOD register
//   volume_we_i  in   write strobe for this channel's VOLUME register
//   ctrl_we_i    in   write strobe for this channel's CTRL register
//   wdata_i      in   write data (shared by all channels)
//   sample_o     out  registered, volume-scaled sample (stage 1)
// ---------------------------------------------------------------------------
module audio_channel
    import audio_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16,
    parameter int SAMPLE_WIDTH = 8,
    parameter int VOL_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    period_we_i,
    input  logic                    volume_we_i,
    input  logic                    ctrl_we_i,
    input  logic [31:0]             wdata_i,
    output logic [SAMPLE_WIDTH-1:0] sample_o
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + VOL_WIDTH;

    // Programmable registers.
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [VOL_WIDTH-1:0]    volume_q, volume_d;
    logic                    enable_q, enable_d;
    wave_mode_e              mode_q, mode_d;

    // Oscillator state.
    logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
    logic [SAMPLE_WIDTH-1:0] phase_q, phase_d;
    logic                    level_q, level_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;

    // Stage-1 pipeline register.
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;

    logic                    active;
    logic                    phase_rst;
    logic                    tick;
    logic [SAMPLE_WIDTH-1:0] tri_fold;
    logic [SAMPLE_WIDTH-1:0] raw;
    logic [PROD_WIDTH-1:0]   product;
    logic                    unused_bits;

    // Upper write-data bits and the fractional product bits are deliberately dropped.
    assign unused_bits = ^{wdata_i, product[VOL_WIDTH-1:0], tri_fold[SAMPLE_WIDTH-1]};

    // -----------------------------------------------------------------------
    // Register file and oscillator next-state
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        period_d  = period_q;
        volume_d  = volume_q;
        enable_d  = enable_q;
        mode_d    = mode_q;
        counter_d = counter_q;
        phase_d   = phase_q;
        level_d   = level_q;
        lfsr_d    = lfsr_q;

        phase_rst = ctrl_we_i && wdata_i[CTRL_PHASE_RST_BIT];
        active    = enable_q && (period_q != '0);

        // A PERIOD write or a phase reset on the same edge swallows the tick.
        tick = active && (counter_q == period_q - PERIOD_WIDTH'(1))
               && !period_we_i && !phase_rst;

        if (period_we_i) begin
            period_d = wdata_i[PERIOD_WIDTH-1:0];
        end
        if (volume_we_i) begin
            volume_d = wdata_i[VOL_WIDTH-1:0];
        end
        if (ctrl_we_i) begin
            enable_d = wdata_i[CTRL_ENABLE_BIT];
            mode_d   = wave_mode_e'(wdata_i[CTRL_MODE_MSB:CTRL_MODE_LSB]);
        end

        // Counter: cleared by PERIOD write or phase reset, wraps on tick,
        // otherwise counts only while the channel is active.
        if (period_we_i || phase_rst || tick) begin
            counter_d = '0;
        end else if (active) begin
            counter_d = counter_q + PERIOD_WIDTH'(1);
        end

        // Waveform state advances on tick, using the mode in force this cycle.
        if (phase_rst) begin
            phase_d = '0;
            level_d = 1'b0;
            lfsr_d  = LFSR_SEED;
        end else if (tick) begin
            case (mode_q)
                MODE_SQUARE: level_d = ~level_q;
                MODE_SAW,
                MODE_TRI:    phase_d = phase_q + SAMPLE_WIDTH'(1);
                MODE_NOISE:  lfsr_d  = lfsr_step(lfsr_q);
                default:     level_d = level_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Waveform selection and volume scaling
    // -----------------------------------------------------------------------
    always_comb begin
        // Fold the upper half of the phase back down, then double it so the
        // triangle spans the full sample range.
        tri_fold = phase_q[SAMPLE_WIDTH-1] ? ~phase_q : phase_q;

        case (mode_q)
            MODE_SQUARE: raw = level_q ? '1 : '0;
            MODE_SAW:    raw = phase_q;
            MODE_TRI:    raw = {tri_fold[SAMPLE_WIDTH-2:0], 1'b0};
            MODE_NOISE:  raw = {SAMPLE_WIDTH{lfsr_q[0]}};
            default:     raw = '0;
        endcase

        // Full-width product; VOLUME < 2^VOL_WIDTH so the shifted result
        // always fits in SAMPLE_WIDTH bits.
        product  = {{VOL_WIDTH{1'b0}}, raw} * {{SAMPLE_WIDTH{1'b0}}, volume_q};
        sample_d = active ? product[PROD_WIDTH-1:VOL_WIDTH] : '0;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q  <= '0;
            volume_q  <= '0;
            enable_q  <= 1'b0;
            mode_q    <= MODE_SQUARE;
            counter_q <= '0;
            phase_q   <= '0;
            level_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            sample_q  <= '0;
        end else begin
            period_q  <= period_d;
            volume_q  <= volume_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            counter_q <= counter_d;
            phase_q   <= phase_d;
            level_q   <= level_d;
            lfsr_q    <= lfsr_d;
            sample_q  <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/audio_synth.sv
// ---------------------------------------------------------------------------
// audio_synth
//
// Multi-voice synthesiser top level. Decodes the register write port into
// per-channel strobes, instantiates CHANNELS voices and sums their stage-1
// samples into the registered stage-2 output.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   wenable  in   register write strobe
//   waddr    in   {channel, reg} write address
//   wdata    in   32-bit write data
//   out      out  mixed unsigned sample, wide enough that the sum never wraps
// ---------------------------------------------------------------------------
module audio_synth
    import audio_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int PERIOD_WIDTH = 16,
    parameter int SAMPLE_WIDTH = 8,
    parameter int VOL_WIDTH    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wenable,
    input  logic [$clog2(CHANNELS)+1:0]              waddr,
    input  logic [31:0]                              wdata,
    output logic [SAMPLE_WIDTH+$clog2(CHANNELS)-1:0] out
);

    localparam int CH_BITS   = $clog2(CHANNELS);
    localparam int CH_IDX_W  = (CH_BITS > 0) ? CH_BITS : 1;
    localparam int OUT_WIDTH = SAMPLE_WIDTH + CH_BITS;

    logic [CH_IDX_W-1:0]     ch_sel;
    reg_sel_e                reg_sel;
    logic [CHANNELS-1:0]     period_we;
    logic [CHANNELS-1:0]     volume_we;
    logic [CHANNELS-1:0]     ctrl_we;
    logic [SAMPLE_WIDTH-1:0] samples [CHANNELS];
    logic [OUT_WIDTH-1:0]    out_q, out_d;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    // A single-channel build has no channel field in the address.
    generate
        if (CH_BITS > 0) begin : g_ch_field
            assign ch_sel = waddr[CH_BITS+1:2];
        end else begin : g_no_ch_field
            assign ch_sel = '0;
        end
    endgenerate

    assign reg_sel = reg_sel_e'(waddr[1:0]);

    // Reserved offset falls through to no strobe at all.
    always_comb begin
        period_we = '0;
        volume_we = '0;
        ctrl_we   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wenable && (ch_sel == CH_IDX_W'(i))) begin
                case (reg_sel)
                    REG_PERIOD: period_we[i] = 1'b1;
                    REG_VOLUME: volume_we[i] = 1'b1;
                    REG_CTRL:   ctrl_we[i]   = 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Voices
    // -----------------------------------------------------------------------
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
            audio_channel #(
                .PERIOD_WIDTH(PERIOD_WIDTH),
                .SAMPLE_WIDTH(SAMPLE_WIDTH),
                .VOL_WIDTH   (VOL_WIDTH)
            ) u_channel (
                .clk        (clk),
                .rst        (rst),
                .period_we_i(period_we[g]),
                .volume_we_i(volume_we[g]),
                .ctrl_we_i  (ctrl_we[g]),
                .wdata_i    (wdata),
                .sample_o   (samples[g])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stage 2: mixer
    // -----------------------------------------------------------------------
    // Each term is zero-extended to the output width, which holds
    // CHANNELS * (2^SAMPLE_WIDTH - 1) without wrapping.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_d = out_d + OUT_WIDTH'(samples[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_audio_synth.sv
// ---------------------------------------------------------------------------
// tb_audio_synth
//
// Directed self-checking bench for audio_synth (default parameters: four
// channels, 16-bit period, 8-bit samples, 4-bit volume, 10-bit out).
// Inputs change on the falling edge; out is sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_audio_synth;

    logic        clk;
    logic        rst;
    logic        wenable;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  out_w;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    audio_synth dut (
        .clk    (clk),
        .rst    (rst),
        .wenable(wenable),
        .waddr  (waddr),
        .wdata  (wdata),
        .out    (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n full clock cycles, ending just after a falling edge.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One register write, taking effect on the next rising edge.
    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        wenable = 1'b1;
        waddr   = addr;
        wdata   = data;
        tick_n(1);
        wenable = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_n(1);
        check("reset_out", 32'(out_w), 32'd0);
        rst = 1'b0;
    endtask

    // Expected out for the triangle voice at phase p, volume 15.
    function automatic int tri_expect(input int p);
        logic [7:0] ph;
        logic [7:0] fold;
        logic [7:0] raw;
        ph   = 8'(p);
        fold = ph[7] ? ~ph : ph;
        raw  = {fold[6:0], 1'b0};
        return (int'(raw) * 15) >> 4;
    endfunction

    // ch3 noise at PERIOD=2, VOLUME=15, checked against a reference LFSR.
    task automatic noise_run(input string tag);
        logic [14:0] ref_lfsr;
        ref_lfsr = 15'h7FFF;
        wr(4'd12, 32'd2);
        wr(4'd13, 32'd15);
        wr(4'd14, 32'h7);
        tick_n(1);
        for (int k = 2; k < 82; k++) begin
            tick_n(1);
            check(tag, 32'(out_w), ref_lfsr[0] ? 32'd239 : 32'd0);
            if (k % 2 == 1) ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[1], ref_lfsr[14:1]};
        end
    endtask

    initial begin
        rst     = 1'b1;
        wenable = 1'b0;
        waddr   = '0;
        wdata   = '0;

        // Reset with random writes in flight, then silence with no writes.
        for (int i = 0; i < 3; i++) begin
            wenable = 1'b1;
            waddr   = 4'($urandom_range(0, 15));
            wdata   = $urandom;
            tick_n(1);
            check("rst_hold", 32'(out_w), 32'd0);
        end
        rst     = 1'b0;
        wenable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_n(1);
            check("post_rst_silent", 32'(out_w), 32'd0);
        end

        // Square on ch0; reserved and wenable=0 writes must not enable it.
        wr(4'd0, 32'd4);
        wr(4'd1, 32'd15);
        wr(4'd3, 32'hFFFF_FFFF);
        waddr = 4'd2;
        wdata = 32'h1;
        for (int i = 0; i < 8; i++) begin
            tick_n(1);
            check("ignored_writes", 32'(out_w), 32'd0);
        end
        wr(4'd2, 32'h1);
        tick_n(5);
        check("square_pre", 32'(out_w), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick_n(1);
            check("square", 32'(out_w), ((k / 4) % 2 == 0) ? 32'd239 : 32'd0);
        end

        // Saw then triangle on ch1, PERIOD=1.
        do_reset();
        wr(4'd4, 32'd1);
        wr(4'd5, 32'd15);
        wr(4'd6, 32'h3);
        tick_n(1);
        for (int k = 0; k < 20; k++) begin
            tick_n(1);
            check("saw", 32'(out_w), 32'((k * 15) >> 4));
        end
        wr(4'd6, 32'hD);
        tick_n(1);
        for (int k = 0; k < 131; k++) begin
            tick_n(1);
            check("triangle", 32'(out_w), 32'(tri_expect(k)));
        end

        // Full mix: phase resets spaced one full square period (16 cycles)
        // apart leave all four voices in phase.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            wr(4'(c * 4), 32'd8);
            wr(4'(c * 4 + 1), 32'd15);
        end
        for (int c = 0; c < 4; c++) begin
            wr(4'(c * 4 + 2), 32'h9);
            if (c < 3) tick_n(15);
        end
        tick_n(1);
        for (int k = 2; k < 34; k++) begin
            tick_n(1);
            check("mix4", 32'(out_w), (((k - 2) / 8) % 2 == 1) ? 32'd956 : 32'd0);
        end
        wr(4'd9, 32'd0);
        tick_n(1);
        for (int k = 2; k < 26; k++) begin
            tick_n(1);
            check("mix3", 32'(out_w), ((k / 8) % 2 == 1) ? 32'd717 : 32'd0);
        end

        // Mid-operation PERIOD writes; ch1 is a constant 239 (noise, no tick).
        do_reset();
        wr(4'd4, 32'd1000);
        wr(4'd5, 32'd15);
        wr(4'd6, 32'h7);
        wr(4'd0, 32'd4);
        wr(4'd1, 32'd15);
        check("ch1_alone", 32'(out_w), 32'd239);
        wr(4'd2, 32'h1);
        tick_n(5);
        check("mid_pre", 32'(out_w), 32'd239);
        wr(4'd0, 32'd0);
        check("period0_e0", 32'(out_w), 32'd478);
        tick_n(1);
        check("period0_e1", 32'(out_w), 32'd478);
        for (int k = 2; k <= 6; k++) begin
            tick_n(1);
            check("period0_hold", 32'(out_w), 32'd239);
        end
        wr(4'd0, 32'd4);
        tick_n(3);
        wr(4'd0, 32'd6);
        tick_n(1);
        for (int k = 6; k <= 18; k++) begin
            tick_n(1);
            check("period_vs_tick", 32'(out_w),
                  (k <= 11 || k == 18) ? 32'd478 : 32'd239);
        end

        // Noise on ch3, then a reset pulse and an identical restart.
        do_reset();
        noise_run("noise");
        rst = 1'b1;
        tick_n(1);
        check("noise_rst_e1", 32'(out_w), 32'd0);
        rst = 1'b0;
        tick_n(1);
        check("noise_rst_e2", 32'(out_w), 32'd0);
        tick_n(1);
        check("noise_rst_e3", 32'(out_w), 32'd0);
        noise_run("noise_restart");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/audio_synth.md
AUDIO_SYNTH -- requirements
Module: audio_synth

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameters SHALL be:
- CHANNELS, default 4: number of voices; a power of two, range 1..16.
- PERIOD_WIDTH, default 16: width of the period register.
- SAMPLE_WIDTH, default 8: width of each voice sample.
- VOL_WIDTH, default 4: width of the volume register.
REQ-003 Ports SHALL be:
- clk  in  1: clock.
- rst  in  1: synchronous active-high reset.
- wenable  in  1: register write strobe.
- waddr  in  $clog2(CHANNELS)+2: {channel, reg}.
- wdata  in  32: write data.
- out  out  SAMPLE_WIDTH+$clog2(CHANNELS): mixed sample, unsigned.

Function
REQ-004 Per-channel registers SHALL be selected by reg = waddr[1:0]:
- 0 = PERIOD, from wdata[PERIOD_WIDTH-1:0].
- 1 = VOLUME, from wdata[VOL_WIDTH-1:0].
- 2 = CTRL: bit0 enable; bits2:1 mode; bit3 phase-reset, write-one strobe, not stored.
- 3 = reserved; writes are ignored.
REQ-005 Each channel SHALL run a period counter that increments every cycle while enabled and PERIOD≠0, and generates a tick and wraps to 0 when counter == PERIOD-1.
REQ-006 A write to PERIOD SHALL clear that channel's counter on the same edge; a write has priority over a simultaneous tick, and no tick is generated that cycle.
REQ-007 Each tick SHALL advance the channel state as follows:
- square: level toggles.
- saw/triangle: phase (SAMPLE_WIDTH bits) increments, wrapping modulo 2^SAMPLE_WIDTH.
- noise: a 15-bit LFSR shifts right, with new bit14 = bit0 XOR bit1.
REQ-008 The raw sample SHALL depend on mode:
- mode 0 (square): level ? 2^SW-1 : 0.
- mode 1 (saw): phase.
- mode 2 (triangle): (phase MSB ? ~phase : phase) shifted left 1, truncated to SW bits.
- mode 3 (noise): all bits = LFSR[0].
REQ-009 The scaled sample SHALL be (raw × VOLUME) >> VOL_WIDTH, computed at full product width and then truncated to SAMPLE_WIDTH; the product cannot overflow.
REQ-010 A channel that is disabled, or has PERIOD=0, SHALL contribute 0 and hold its counter, phase, level and LFSR unchanged.
REQ-011 A CTRL write with bit3=1 SHALL clear counter, phase and level and reseed the LFSR to 15'h7FFF on that edge; this reset has priority over a tick.
REQ-012 Pipeline timing SHALL be:
- Stage 1: scaled per-channel samples are registered.
- Stage 2: `out` is registered as the sum of all stage-1 values.
- A state change at edge E SHALL be visible on `out` at edge E+2.
REQ-013 The sum SHALL never overflow: maximum value is CHANNELS×(2^SW-1), which fits in the `out` width.
REQ-014 Writes to the reserved register, or with wenable=0, SHALL have no effect.

Reset
REQ-015 While rst=1 at an edge, the following SHALL be cleared: all PERIOD, VOLUME, enable and mode registers; counters; phases; levels; both pipeline stages; and `out`.
REQ-016 Every LFSR SHALL reseed to 15'h7FFF on reset, and reset SHALL override any simultaneous write.
REQ-017 Reset asserted mid-operation SHALL force `out`=0 on the next edge, and no stale pipeline value SHALL emerge after rst deasserts.

Structure
REQ-018 A shared package audio_pkg SHALL hold:
- mode encodings (SQUARE=0, SAW=1, TRI=2, NOISE=3);
- register offsets (PERIOD=0, VOLUME=1, CTRL=2);
- CTRL bit positions;
- LFSR seed and taps.
REQ-019 One voice SHALL be a sub-module, audio_channel, instantiated CHANNELS times via generate. It SHALL contain the registers, counter, waveform generator, volume scaling and stage-1 register.
REQ-020 audio_synth SHALL contain only address decode, per-channel write strobes and the stage-2 adder tree/register.

Verification
REQ-021 Reset: rst=1 for 3 cycles with random writes applied → `out`=0; all channels silent after release with no writes.
REQ-022 Square: ch0 PERIOD=4, VOLUME=15, CTRL=0x1 → `out` alternates 239 and 0, 4 cycles each, with first 239 at 2 cycles after the first tick.
REQ-023 Saw/triangle: ch1 PERIOD=1, VOLUME=15, mode saw → `out` sequence (p×15)>>4 for p=0,1,2…; mode triangle after phase-reset → 0,1,3,5… (2p×15>>4) up to the peak, then descending.
REQ-024 Full mix: all 4 channels square, PERIOD=8, VOLUME=15, simultaneous phase-reset → `out` alternates 956 and 0 with no wrap; same test with VOLUME=0 on ch2 → 717.
REQ-025 Mid-operation: ch0 running; write PERIOD=0 → ch0 contribution is 0 at E+2 with ch1 unaffected; write PERIOD=6 in the same cycle as a tick → counter 0, no tick that cycle.
REQ-026 Noise: ch3 PERIOD=2, VOLUME=15, mode noise → output bits follow the reference LFSR model from seed 7FFF (first sample 239); rst pulse mid-stream reseeds, and the sequence restarts identically.
